// File: rtl/accum_pkg.sv
// accum_pkg: shared types, default widths and the saturating-add helper
// for the accum_bank accumulator.
package accum_pkg;

  localparam int unsigned DATAW_DEF  = 32;
  localparam int unsigned ACCUMW_DEF = 40;
  localparam int unsigned CNTW_DEF   = 16;

  typedef logic signed [DATAW_DEF-1:0]  data_t;
  typedef logic signed [ACCUMW_DEF-1:0] acc_t;
  typedef logic        [CNTW_DEF-1:0]   cnt_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACCUMW_DEF-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACCUMW_DEF-1){1'b0}}};

  // Widest supported lane width. Operands are sign-extended into this
  // width so one helper serves any ACCUMW up to MAXW.
  localparam int unsigned MAXW = 64;
  typedef logic signed [MAXW-1:0] wide_t;

  typedef struct packed {
    logic  sat;
    wide_t val;
  } sat_res_t;

  // Adds two w-bit signed values (sign-extended to MAXW) and clamps the
  // result to the signed w-bit range, flagging when a clamp occurred.
  function automatic sat_res_t sat_add(input wide_t a, input wide_t b,
                                       input int unsigned w);
    logic signed [MAXW:0] s;
    logic signed [MAXW:0] hi;
    logic signed [MAXW:0] lo;
    sat_res_t             r;
    s  = {a[MAXW-1], a} + {b[MAXW-1], b};
    hi = ((MAXW+1)'(1) << (w - 1)) - (MAXW+1)'(1);
    lo = -hi - (MAXW+1)'(1);
    r.sat = 1'b0;
    r.val = s[MAXW-1:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.val = hi[MAXW-1:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.val = lo[MAXW-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/accum_bank_lane.sv
// accum_lane: one lane's accumulator register, adder and saturation sticky.
// Saturating add is built when ACCUM_SAT_EN is defined; otherwise the add
// wraps and sat_next is tied low.
module accum_lane
  import accum_pkg::*;
#(
  parameter int unsigned DATAW  = 32,
  parameter int unsigned ACCUMW = 40
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              accept,
  input  logic              first,
  input  logic              last,
  input  logic [DATAW-1:0]  din,
  output logic [ACCUMW-1:0] acc_next,
  output logic              sat_next
);

  logic signed [DATAW-1:0]  din_s;
  logic signed [ACCUMW-1:0] din_ext;
  logic signed [ACCUMW-1:0] base;
  logic        [ACCUMW-1:0] acc_q, acc_d;

  assign din_s   = din;
  assign din_ext = ACCUMW'(din_s);
  assign base    = first ? '0 : acc_q;

`ifdef ACCUM_SAT_EN
  logic     sticky_q, sticky_d;
  sat_res_t add_r;

  // Saturating add and sticky update; sticky restarts on first.
  always_comb begin
    add_r    = sat_add(wide_t'(base), wide_t'(din_ext), ACCUMW);
    acc_next = add_r.val[ACCUMW-1:0];
    sat_next = (first ? 1'b0 : sticky_q) | add_r.sat;
    sticky_d = sticky_q;
    if (accept) sticky_d = last ? 1'b0 : sat_next;
  end

  // Sticky saturation flag register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end
`else
  // Wrapping add; no saturation tracking.
  always_comb begin
    acc_next = base + din_ext;
    sat_next = 1'b0;
  end
`endif

  // Next accumulator: cleared after a completed vector, else the new sum.
  always_comb begin
    acc_d = acc_q;
    if (accept) acc_d = last ? '0 : acc_next;
  end

  // Accumulator register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/accum_bank.sv
// accum_bank: LANES-wide signed accumulator delimited by first/last with a
// registered valid/ready result. Optional ACCUM_SAT_EN selects saturating
// per-lane adds with sticky osat reporting.
module accum_bank
  import accum_pkg::*;
#(
  parameter int unsigned DATAW  = 32,
  parameter int unsigned ACCUMW = 40,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNTW   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATAW-1:0]  data,
  input  logic                    ivalid,
  input  logic                    first,
  input  logic                    last,
  output logic                    iready,
  output logic [LANES*ACCUMW-1:0] result,
  output logic [CNTW-1:0]         obeats,
  output logic [LANES-1:0]        osat,
  output logic                    ovalid,
  input  logic                    oready
);

  logic                    accept;
  logic [LANES*ACCUMW-1:0] lane_acc_next;
  logic [LANES-1:0]        lane_sat;
  logic [CNTW-1:0]         cnt_q, cnt_d, cnt_next;
  logic [LANES*ACCUMW-1:0] result_q, result_d;
  logic [CNTW-1:0]         obeats_q, obeats_d;
  logic [LANES-1:0]        osat_q, osat_d;
  logic                    ovalid_q, ovalid_d;

  assign iready = ~rst & ~(ovalid_q & ~oready);
  assign accept = ivalid & iready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    accum_lane #(
      .DATAW  (DATAW),
      .ACCUMW (ACCUMW)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (accept),
      .first    (first),
      .last     (last),
      .din      (data[i*DATAW +: DATAW]),
      .acc_next (lane_acc_next[i*ACCUMW +: ACCUMW]),
      .sat_next (lane_sat[i])
    );
  end

  // Beat count, output register load and valid handshake.
  always_comb begin
    cnt_d    = cnt_q;
    result_d = result_q;
    obeats_d = obeats_q;
    osat_d   = osat_q;
    ovalid_d = ovalid_q;
    if (first)               cnt_next = CNTW'(1);
    else if (&cnt_q)         cnt_next = cnt_q;
    else                     cnt_next = cnt_q + CNTW'(1);
    if (ovalid_q && oready)  ovalid_d = 1'b0;
    if (accept) begin
      if (last) begin
        result_d = lane_acc_next;
        obeats_d = cnt_next;
        osat_d   = lane_sat;
        ovalid_d = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d    = cnt_next;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      result_q <= '0;
      obeats_q <= '0;
      osat_q   <= '0;
      ovalid_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      result_q <= result_d;
      obeats_q <= obeats_d;
      osat_q   <= osat_d;
      ovalid_q <= ovalid_d;
    end
  end

  assign result = result_q;
  assign obeats = obeats_q;
  assign osat   = osat_q;
  assign ovalid = ovalid_q;

endmodule

// File: tb/tb_accum_bank.sv
// tb_accum_bank: directed self-checking bench for accum_bank (default
// 4-lane instance plus a narrow 8-bit instance for overflow behaviour).
module tb_accum_bank;

  logic         clk;
  logic         rst;
  logic [127:0] data;
  logic         ivalid, first, last, oready;
  logic         iready, ovalid;
  logic [159:0] result;
  logic [15:0]  obeats;
  logic [3:0]   osat;

  logic [15:0]  s_data;
  logic         s_ivalid, s_first, s_last, s_oready;
  logic         s_iready, s_ovalid;
  logic [15:0]  s_result;
  logic [3:0]   s_obeats;
  logic [1:0]   s_osat;

  int ntests = 0;
  int nfail  = 0;
  logic [159:0] held;

  accum_bank #(.DATAW(32), .ACCUMW(40), .LANES(4), .CNTW(16)) u_dut (
    .clk(clk), .rst(rst), .data(data), .ivalid(ivalid), .first(first),
    .last(last), .iready(iready), .result(result), .obeats(obeats),
    .osat(osat), .ovalid(ovalid), .oready(oready)
  );

  accum_bank #(.DATAW(8), .ACCUMW(8), .LANES(2), .CNTW(4)) u_small (
    .clk(clk), .rst(rst), .data(s_data), .ivalid(s_ivalid), .first(s_first),
    .last(s_last), .iready(s_iready), .result(s_result), .obeats(s_obeats),
    .osat(s_osat), .ovalid(s_ovalid), .oready(s_oready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] pk(input int a0, a1, a2, a3);
    return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
  endfunction

  function automatic logic [159:0] pr(input int a0, a1, a2, a3);
    return {40'(a3), 40'(a2), 40'(a1), 40'(a0)};
  endfunction

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One accepted beat on the main instance; outputs sampled 1 time unit after the edge.
  task automatic beat(input logic [127:0] d, input logic f, input logic l);
    data = d; first = f; last = l; ivalid = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b0; first = 1'b0; last = 1'b0;
  endtask

  task automatic sbeat(input logic [15:0] d, input logic f, input logic l);
    s_data = d; s_first = f; s_last = l; s_ivalid = 1'b1;
    @(posedge clk); #1;
    s_ivalid = 1'b0; s_first = 1'b0; s_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; data = '0; ivalid = 0; first = 0; last = 0; oready = 1'b1;
    s_data = '0; s_ivalid = 0; s_first = 0; s_last = 0; s_oready = 1'b1;
    @(posedge clk); #1;
    chk("rst_result", result, '0);
    chk("rst_ovalid", 160'(ovalid), 160'(0));
    chk("rst_obeats", 160'(obeats), 160'(0));
    chk("rst_osat",   160'(osat), 160'(0));
    chk("rst_iready", 160'(iready), 160'(0));
    rst = 1'b0;
    #1 chk("post_rst_iready", 160'(iready), 160'(1));

    // Three-beat vector
    beat(pk(5, 1, -3, 0), 1, 0);
    chk("t1_no_ovalid", 160'(ovalid), 160'(0));
    beat(pk(-2, 2, 4, 7), 0, 0);
    beat(pk(10, 0, 0, -7), 0, 1);
    chk("t1_ovalid", 160'(ovalid), 160'(1));
    chk("t1_result", result, pr(13, 3, 1, 0));
    chk("t1_obeats", 160'(obeats), 160'(3));
    chk("t1_osat",   160'(osat), 160'(0));
    @(posedge clk); #1;
    chk("t1_ovalid_drop", 160'(ovalid), 160'(0));

    // Single first&last beat, then a beat without first
    beat(pk(-1, 2, 3, 4), 1, 1);
    chk("t2_result", result, pr(-1, 2, 3, 4));
    chk("t2_obeats", 160'(obeats), 160'(1));
    beat(pk(1, 1, 1, 1), 0, 1);
    chk("t2_nofirst_result", result, pr(1, 1, 1, 1));
    chk("t2_nofirst_obeats", 160'(obeats), 160'(1));
    @(posedge clk); #1;

    // Backpressure
    oready = 1'b0;
    beat(pk(1, 2, 3, 4), 1, 0);
    beat(pk(1, 1, 1, 1), 0, 1);
    chk("t3_ovalid", 160'(ovalid), 160'(1));
    chk("t3_result", result, pr(2, 3, 4, 5));
    chk("t3_obeats", 160'(obeats), 160'(2));
    chk("t3_iready_low", 160'(iready), 160'(0));
    held = result;
    data = pk(100, 200, 300, 400); first = 1'b1; last = 1'b0; ivalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t3_hold_iready", 160'(iready), 160'(0));
      chk("t3_hold_ovalid", 160'(ovalid), 160'(1));
      chk("t3_hold_result", result, held);
    end
    oready = 1'b1;
    #1 chk("t3_iready_up", 160'(iready), 160'(1));
    @(posedge clk); #1;
    ivalid = 1'b0; first = 1'b0;
    chk("t3_ovalid_drop", 160'(ovalid), 160'(0));
    beat(pk(1, 1, 1, 1), 0, 1);
    chk("t3_held_accepted", result, pr(101, 201, 301, 401));
    chk("t3_held_obeats", 160'(obeats), 160'(2));

    // Back-to-back single-beat vectors
    beat(pk(7, 7, 7, 7), 1, 1);
    chk("t4_result7", result, pr(7, 7, 7, 7));
    chk("t4_ovalid7", 160'(ovalid), 160'(1));
    beat(pk(9, 9, 9, 9), 1, 1);
    chk("t4_result9", result, pr(9, 9, 9, 9));
    chk("t4_ovalid9", 160'(ovalid), 160'(1));
    @(posedge clk); #1;
    chk("t4_ovalid_drop", 160'(ovalid), 160'(0));

    // Bubble mid-vector
    beat(pk(3, -4, 5, 6), 1, 0);
    data = pk(50, 50, 50, 50);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("t5_bubble_ovalid", 160'(ovalid), 160'(0));
    end
    beat(pk(2, 2, 2, 2), 0, 0);
    beat(pk(1, 1, 1, 1), 0, 1);
    chk("t5_result", result, pr(6, -1, 8, 9));
    chk("t5_obeats", 160'(obeats), 160'(3));

    // Narrow instance overflow: lane0 100+100, lane1 0+(-1)
    sbeat({8'sd0, 8'sd100}, 1, 0);
    sbeat({8'hff, 8'sd100}, 0, 1);
    chk("t6_s_ovalid", 160'(s_ovalid), 160'(1));
    chk("t6_s_obeats", 160'(s_obeats), 160'(2));
`ifdef ACCUM_SAT_EN
    chk("t6_s_result", 160'(s_result), 160'(16'hff7f));
    chk("t6_s_osat",   160'(s_osat), 160'(2'b01));
`else
    chk("t6_s_result", 160'(s_result), 160'(16'hffc8));
    chk("t6_s_osat",   160'(s_osat), 160'(2'b00));
`endif
    sbeat({8'sd1, 8'sd1}, 1, 1);
    chk("t6_s_next_result", 160'(s_result), 160'(16'h0101));
    chk("t6_s_next_osat",   160'(s_osat), 160'(2'b00));

    // Asynchronous reset mid-vector
    beat(pk(5, 5, 5, 5), 1, 0);
    #2 rst = 1'b1;
    #1;
    chk("t7_rst_result", result, '0);
    chk("t7_rst_ovalid", 160'(ovalid), 160'(0));
    chk("t7_rst_obeats", 160'(obeats), 160'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;
    beat(pk(2, 2, 2, 2), 0, 1);
    chk("t7_after_rst_result", result, pr(2, 2, 2, 2));
    chk("t7_after_rst_obeats", 160'(obeats), 160'(1));

    // Asynchronous reset with a pending result
    oready = 1'b0;
    beat(pk(8, 8, 8, 8), 1, 1);
    chk("t8_pending", 160'(ovalid), 160'(1));
    #3 rst = 1'b1;
    #1;
    chk("t8_rst_ovalid", 160'(ovalid), 160'(0));
    chk("t8_rst_result", result, '0);
    chk("t8_rst_s_result", 160'(s_result), 160'(0));
    #1 rst = 1'b0;
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
